ad1xx_retire_trace: RTL

- Synthesizable retire-trace buffer for the ad1xx CPU family.
- Generalises the bench-side pc/instruction/register dump into an on-chip circular capture of retired instructions.
- Each entry holds: retired PC, instruction word, WATCH_REGS selected register values.
- PC-match trigger, programmable post-trigger depth, oldest-first readout; sits beside the core's retire stage, read by debug logic or a bench.

---
 rtl/ad1xx_retire_trace_if.sv | 59 +++++
 rtl/ad1xx_retire_trace.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ad1xx_retire_trace_if.sv
`default_nettype none
// ============================================================================
//  Module   : ad1xx_retire_trace_if
//  Purpose  : Bundle of retire-capture, control and readout signals for the
//             ad1xx retire-trace buffer. The slave modport is the buffer's
//             view; the master modport is the core/debug/bench side.
//             Optional macro: AD1XX_TRACE_TIMESTAMP_EN adds rd_timestamp.
//  Revision : 1.0 - initial release
// ============================================================================
interface ad1xx_retire_trace_if #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int WATCH_REGS = 1,
    parameter int CNT_W      = $clog2(DEPTH) + 1
);
    logic                       retire_valid;
    logic [XLEN-1:0]            retire_pc;
    logic [31:0]                retire_inst;
    logic [WATCH_REGS*XLEN-1:0] watch_data;
    logic                       arm;
    logic [XLEN-1:0]            trigger_pc;
    logic [CNT_W-1:0]           post_count;
    logic                       rd_en;
    logic                       rd_valid;
    logic [XLEN-1:0]            rd_pc;
    logic [31:0]                rd_inst;
    logic [WATCH_REGS*XLEN-1:0] rd_watch;
    logic [CNT_W-1:0]           count;
    logic [1:0]                 state;
    logic                       wrapped;
`ifdef AD1XX_TRACE_TIMESTAMP_EN
    logic [31:0]                rd_timestamp;

    modport master (
        output retire_valid, retire_pc, retire_inst, watch_data,
        output arm, trigger_pc, post_count, rd_en,
        input  rd_valid, rd_pc, rd_inst, rd_watch, count, state, wrapped,
        input  rd_timestamp
    );
    modport slave (
        input  retire_valid, retire_pc, retire_inst, watch_data,
        input  arm, trigger_pc, post_count, rd_en,
        output rd_valid, rd_pc, rd_inst, rd_watch, count, state, wrapped,
        output rd_timestamp
    );
`else
    modport master (
        output retire_valid, retire_pc, retire_inst, watch_data,
        output arm, trigger_pc, post_count, rd_en,
        input  rd_valid, rd_pc, rd_inst, rd_watch, count, state, wrapped
    );
    modport slave (
        input  retire_valid, retire_pc, retire_inst, watch_data,
        input  arm, trigger_pc, post_count, rd_en,
        output rd_valid, rd_pc, rd_inst, rd_watch, count, state, wrapped
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ad1xx_retire_trace.sv
`default_nettype none
// ============================================================================
//  Module   : ad1xx_retire_trace
//  Purpose  : Circular capture of retired instructions (PC, instruction word,
//             selected register values) with PC-match trigger, clamped
//             post-trigger depth and oldest-first readout.
//             Optional macro: AD1XX_TRACE_TIMESTAMP_EN stores a free-running
//             32-bit cycle count per entry and returns it on rd_timestamp.
//  Revision : 1.0 - initial release
// ============================================================================
module ad1xx_retire_trace #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int WATCH_REGS = 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    ad1xx_retire_trace_if.slave     tr
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WW    = WATCH_REGS * XLEN;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_max_post = CNT_W'(DEPTH - 1);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, remaining_q;
    logic             wrapped_q;
    logic             rd_valid_q;
    logic [XLEN-1:0]  rd_pc_q;
    logic [31:0]      rd_inst_q;
    logic [WW-1:0]    rd_watch_q;

    logic [XLEN-1:0]  mem_pc_q    [DEPTH];
    logic [31:0]      mem_inst_q  [DEPTH];
    logic [WW-1:0]    mem_watch_q [DEPTH];

    logic             w_cap;
    logic             w_pop;
    logic             w_trig_hit;
    logic [CNT_W-1:0] w_eff;

`ifdef AD1XX_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] rd_ts_q;
    logic [31:0] mem_ts_q [DEPTH];
`endif

    // State register; arm handling lives in the next-state logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: arm overrides everything, trigger/post countdown otherwise
    always_comb begin
        state_d = state_q;
        if (tr.arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: if (w_trig_hit) state_d = (w_eff == '0) ? S_DONE : S_POST;
                S_POST:  if (tr.retire_valid && remaining_q == CNT_W'(1)) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Output/control decode: capture and pop strobes, clamped post depth
    always_comb begin
        w_cap      = !tr.arm && tr.retire_valid && (state_q == S_ARMED || state_q == S_POST);
        w_trig_hit = !tr.arm && tr.retire_valid && (state_q == S_ARMED) &&
                     (tr.retire_pc == tr.trigger_pc);
        w_pop      = !tr.arm && tr.rd_en && (state_q == S_DONE) && (count_q != '0);
        w_eff      = (tr.post_count > c_max_post) ? c_max_post : tr.post_count;
    end

    // Pointers, occupancy, post-trigger countdown and readout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            wrapped_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_pc_q     <= '0;
            rd_inst_q   <= '0;
            rd_watch_q  <= '0;
        end else if (tr.arm) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            wrapped_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= w_pop;
            if (w_cap) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                // A full buffer drops its oldest entry to make room
                if (count_q == c_depth) begin
                    rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                    wrapped_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                end
                if (w_trig_hit)            remaining_q <= w_eff;
                else if (state_q == S_POST) remaining_q <= remaining_q - CNT_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                count_q    <= count_q - CNT_W'(1);
                rd_pc_q    <= mem_pc_q[rd_ptr_q];
                rd_inst_q  <= mem_inst_q[rd_ptr_q];
                rd_watch_q <= mem_watch_q[rd_ptr_q];
            end
        end
    end

    // Entry storage; contents are never visible while count is zero
    always_ff @(posedge clk) begin
        if (w_cap) begin
            mem_pc_q[wr_ptr_q]    <= tr.retire_pc;
            mem_inst_q[wr_ptr_q]  <= tr.retire_inst;
            mem_watch_q[wr_ptr_q] <= tr.watch_data;
        end
    end

`ifdef AD1XX_TRACE_TIMESTAMP_EN
    // Free-running cycle counter and the timestamp readout register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q    <= '0;
            rd_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (w_pop) rd_ts_q <= mem_ts_q[rd_ptr_q];
        end
    end

    // Timestamp storage alongside each entry
    always_ff @(posedge clk) begin
        if (w_cap) mem_ts_q[wr_ptr_q] <= ts_q;
    end

    assign tr.rd_timestamp = rd_ts_q;
`endif

    assign tr.rd_valid = rd_valid_q;
    assign tr.rd_pc    = rd_pc_q;
    assign tr.rd_inst  = rd_inst_q;
    assign tr.rd_watch = rd_watch_q;
    assign tr.count    = count_q;
    assign tr.state    = state_q;
    assign tr.wrapped  = wrapped_q;

endmodule
`default_nettype wire
